// File: rtl/snake_pkg.sv
// Shared constants for the NES pad reader: button bit positions and FSM states.
package snake_pkg;

    // Bit positions inside o_buttons, in pad shift order (A is shifted out first)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_BUTTONS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_HI = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_DONE   = 3'd4
    } pad_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV system clocks.
module tick_gen #(
    parameter int unsigned CLK_DIV = 300
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1 and wrap on the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller poller: strobes latch, clocks out 8 serial bits, publishes them
// as active-high buttons and derives registered game-control levels.
module nes_pad_reader
    import snake_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 300,
    parameter int unsigned POLL_TICKS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_pad_data,
    output logic       o_pad_latch,
    output logic       o_pad_clk,
    output logic [7:0] o_buttons,
    output logic       o_valid,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_pause,
    output logic       o_restart
);

    localparam int unsigned PW = $clog2(POLL_TICKS);

    logic                   tick;
    logic [1:0]             sync;
    logic                   pad_bit;
    pad_state_e             state;
    logic                   latch_ph;
    logic [2:0]             bit_cnt;
    logic [NUM_BUTTONS-1:0] shadow;
    logic [PW-1:0]          poll_cnt;
    logic                   start;

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign pad_bit = sync[1];
    assign start   = tick && i_enable && (state == ST_IDLE) && (poll_cnt == '0);

    // Two-flop synchronizer for the asynchronous pad data line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], i_pad_data};
        end
    end

    // Poll counter: runs modulo POLL_TICKS from a frame start, parks at 0 when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (!i_enable) begin
            poll_cnt <= '0;
        end else if (tick && (start || poll_cnt != '0)) begin
            poll_cnt <= (poll_cnt == PW'(POLL_TICKS - 1)) ? '0 : poll_cnt + 1'b1;
        end
    end

    // Frame sequencer; pad strobes are registered so they never glitch on state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            latch_ph    <= 1'b0;
            bit_cnt     <= '0;
            shadow      <= '0;
            o_pad_latch <= 1'b0;
            o_pad_clk   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_LATCH;
                        latch_ph    <= 1'b0;
                        o_pad_latch <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        if (latch_ph) begin
                            // Pad presents A while latched; inverted since pad is active-low
                            shadow      <= {~pad_bit, shadow[NUM_BUTTONS-1:1]};
                            bit_cnt     <= 3'd1;
                            o_pad_latch <= 1'b0;
                            o_pad_clk   <= 1'b1;
                            state       <= ST_CLK_HI;
                        end else begin
                            latch_ph <= 1'b1;
                        end
                    end
                end
                ST_CLK_HI: begin
                    if (tick) begin
                        o_pad_clk <= 1'b0;
                        state     <= ST_CLK_LO;
                    end
                end
                ST_CLK_LO: begin
                    if (tick) begin
                        shadow <= {~pad_bit, shadow[NUM_BUTTONS-1:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_DONE;
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            o_pad_clk <= 1'b1;
                            state     <= ST_CLK_HI;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    o_pad_latch <= 1'b0;
                    o_pad_clk   <= 1'b0;
                end
            endcase
        end
    end

    // Publish a completed frame; o_valid coincides with the new o_buttons value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_buttons <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                o_buttons <= shadow;
            end
        end
    end

    // Game controls, one cycle behind o_buttons; opposing directions cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_up      <= 1'b0;
            o_down    <= 1'b0;
            o_left    <= 1'b0;
            o_right   <= 1'b0;
            o_pause   <= 1'b0;
            o_restart <= 1'b0;
        end else begin
            o_up      <= o_buttons[BTN_UP] & ~o_buttons[BTN_DOWN];
            o_down    <= o_buttons[BTN_DOWN] & ~o_buttons[BTN_UP];
            o_left    <= o_buttons[BTN_LEFT] & ~o_buttons[BTN_RIGHT];
            o_right   <= o_buttons[BTN_RIGHT] & ~o_buttons[BTN_LEFT];
            o_pause   <= o_buttons[BTN_START];
            o_restart <= o_buttons[BTN_SELECT];
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural 4021-style pad model.
module tb_nes_pad_reader;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned POLL_TICKS = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_enable;
    logic       i_pad_data;
    logic       o_pad_latch;
    logic       o_pad_clk;
    logic [7:0] o_buttons;
    logic       o_valid;
    logic       o_up;
    logic       o_down;
    logic       o_left;
    logic       o_right;
    logic       o_pause;
    logic       o_restart;
    logic [5:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;

    // Pad model state: buttons are active-high here, driven active-low on the wire
    logic [7:0] pad_buttons = 8'h00;
    logic       pad_stuck   = 1'b0;
    logic [7:0] pad_sr      = 8'h00;

    nes_pad_reader #(
        .CLK_DIV   (CLK_DIV),
        .POLL_TICKS(POLL_TICKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_pad_data (i_pad_data),
        .o_pad_latch(o_pad_latch),
        .o_pad_clk  (o_pad_clk),
        .o_buttons  (o_buttons),
        .o_valid    (o_valid),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_left     (o_left),
        .o_right    (o_right),
        .o_pause    (o_pause),
        .o_restart  (o_restart)
    );

    assign ctl = {o_up, o_down, o_left, o_right, o_pause, o_restart};

    always #5 clk = ~clk;

    // Parallel load on latch, shift towards bit 0 on each pad clock rise
    always @(posedge o_pad_latch or posedge o_pad_clk) begin
        if (o_pad_latch) pad_sr = pad_buttons;
        else             pad_sr = {1'b0, pad_sr[7:1]};
    end

    assign i_pad_data = pad_stuck ? 1'b1 : ~pad_sr[0];

    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_latch_rise(input int limit, output bit seen, output int cycles);
        logic prev;
        prev   = o_pad_latch;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (o_pad_latch && !prev) seen = 1'b1;
            prev = o_pad_latch;
        end
    endtask

    task automatic test_reset();
        bit seen;
        int cyc;
        rst = 1'b1;
        i_enable = 1'b0;
        pad_buttons = 8'h11;
        repeat (3) @(negedge clk);
        i_enable = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({o_pad_latch, o_pad_clk} !== 2'b00)
            $display("FAIL reset_pad_lines: got %b want 00", {o_pad_latch, o_pad_clk});
        else n_pass++;
        n_checks++;
        if (o_buttons !== 8'h00) $display("FAIL reset_buttons: got %h want 00", o_buttons);
        else n_pass++;
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid);
        else n_pass++;
        n_checks++;
        if (ctl !== 6'b000000) $display("FAIL reset_controls: got %b want 000000", ctl);
        else n_pass++;
        // First frame should start on the very first tick after release
        rst = 1'b0;
        wait_latch_rise(50, seen, cyc);
        n_checks++;
        if (!seen || cyc != 4)
            $display("FAIL startup_latency: got seen=%0d cycles=%0d want 1/4", seen, cyc);
        else n_pass++;
    endtask

    task automatic test_up_a();
        bit seen;
        int nvalid;
        wait_valid(200, seen);
        n_checks++;
        if (!seen) $display("FAIL up_a_valid: got no valid want pulse");
        else n_pass++;
        n_checks++;
        if (o_buttons !== 8'h11) $display("FAIL up_a_buttons: got %h want 11", o_buttons);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b0) $display("FAIL valid_width: got %b want 0", o_valid);
        else n_pass++;
        n_checks++;
        if (ctl !== 6'b100000) $display("FAIL up_a_controls: got %b want 100000", ctl);
        else n_pass++;
        nvalid = 0;
        for (int i = 0; i < 199; i++) begin
            @(negedge clk);
            if (o_valid) nvalid++;
        end
        n_checks++;
        if (nvalid != 1) $display("FAIL valid_per_frame: got %0d want 1", nvalid);
        else n_pass++;
    endtask

    task automatic test_timing();
        bit   seen;
        int   cyc;
        int   lat_len;
        bit   lat_open;
        int   pulses;
        int   bad;
        int   run;
        int   spacing;
        logic prev_clk;
        logic prev_lat;
        wait_latch_rise(200, seen, cyc);
        n_checks++;
        if (!seen) $display("FAIL timing_latch_seen: got none want rise");
        else n_pass++;
        lat_len  = 1;
        lat_open = 1'b1;
        pulses   = 0;
        bad      = 0;
        run      = 0;
        spacing  = -1;
        prev_clk = o_pad_clk;
        prev_lat = o_pad_latch;
        for (int i = 1; i <= 200 && spacing < 0; i++) begin
            @(negedge clk);
            if (lat_open) begin
                if (o_pad_latch) lat_len++;
                else lat_open = 1'b0;
            end else if (o_pad_latch && !prev_lat) begin
                spacing = i;
            end
            if (o_pad_clk != prev_clk) begin
                if (prev_clk) begin
                    if (run != 4) bad++;
                end else if (pulses > 0 && run != 4) begin
                    bad++;
                end
                if (o_pad_clk) pulses++;
                run = 1;
            end else begin
                run++;
            end
            prev_clk = o_pad_clk;
            prev_lat = o_pad_latch;
        end
        n_checks++;
        if (lat_len != 8) $display("FAIL latch_width: got %0d want 8", lat_len);
        else n_pass++;
        n_checks++;
        if (pulses != 7) $display("FAIL pad_clk_pulses: got %0d want 7", pulses);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL pad_clk_widths: got %0d bad phases want 0", bad);
        else n_pass++;
        n_checks++;
        if (spacing != 160) $display("FAIL frame_spacing: got %0d want 160", spacing);
        else n_pass++;
    endtask

    task automatic test_left_right_start();
        bit seen;
        int stale;
        wait_valid(200, seen);
        pad_buttons = 8'hC8;
        seen  = 1'b0;
        stale = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
            else if (o_buttons !== 8'h11) stale++;
        end
        n_checks++;
        if (!seen || stale != 0)
            $display("FAIL buttons_hold: got seen=%0d early_changes=%0d want 1/0", seen, stale);
        else n_pass++;
        n_checks++;
        if (o_buttons !== 8'hC8) $display("FAIL lrs_buttons: got %h want c8", o_buttons);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000010) $display("FAIL lrs_controls: got %b want 000010", ctl);
        else n_pass++;
    endtask

    task automatic test_absent();
        bit seen;
        pad_stuck = 1'b1;
        wait_valid(200, seen);
        n_checks++;
        if (!seen) $display("FAIL absent_valid: got no valid want pulse");
        else n_pass++;
        n_checks++;
        if (o_buttons !== 8'h00) $display("FAIL absent_buttons: got %h want 00", o_buttons);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b000000) $display("FAIL absent_controls: got %b want 000000", ctl);
        else n_pass++;
    endtask

    task automatic test_select_down();
        bit seen;
        pad_stuck = 1'b0;
        pad_buttons = 8'h24;
        wait_valid(200, seen);
        n_checks++;
        if (!seen || o_buttons !== 8'h24)
            $display("FAIL sel_down_buttons: got seen=%0d %h want 1/24", seen, o_buttons);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b010001) $display("FAIL sel_down_controls: got %b want 010001", ctl);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit   seen;
        int   cyc;
        int   rises;
        int   nvalid;
        logic prev;
        pad_buttons = 8'h11;
        wait_latch_rise(200, seen, cyc);
        rises = 0;
        prev  = o_pad_clk;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            @(negedge clk);
            if (o_pad_clk && !prev) rises++;
            prev = o_pad_clk;
        end
        n_checks++;
        if (!seen || rises != 3)
            $display("FAIL mid_reset_reach: got latch=%0d rises=%0d want 1/3", seen, rises);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({o_pad_latch, o_pad_clk, o_valid} !== 3'b000)
            $display("FAIL mid_reset_lines: got %b want 000", {o_pad_latch, o_pad_clk, o_valid});
        else n_pass++;
        n_checks++;
        if (o_buttons !== 8'h00 || ctl !== 6'b000000)
            $display("FAIL mid_reset_outputs: got %h/%b want 00/000000", o_buttons, ctl);
        else n_pass++;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) nvalid++;
        end
        rst = 1'b0;
        wait_latch_rise(50, seen, cyc);
        n_checks++;
        if (!seen || cyc != 4)
            $display("FAIL restart_latency: got seen=%0d cycles=%0d want 1/4", seen, cyc);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        n_checks++;
        if (nvalid != 0 || !seen || o_buttons !== 8'h11)
            $display("FAIL restart_frame: got stray=%0d seen=%0d %h want 0/1/11",
                     nvalid, seen, o_buttons);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit   seen;
        int   cyc;
        int   lat_rises;
        int   nvalid;
        logic prev;
        pad_buttons = 8'h90;
        wait_latch_rise(200, seen, cyc);
        i_enable = 1'b0;
        wait_valid(100, seen);
        n_checks++;
        if (!seen || o_buttons !== 8'h90)
            $display("FAIL drop_frame: got seen=%0d %h want 1/90", seen, o_buttons);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ctl !== 6'b100100) $display("FAIL drop_controls: got %b want 100100", ctl);
        else n_pass++;
        lat_rises = 0;
        nvalid    = 0;
        prev      = o_pad_latch;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (o_pad_latch && !prev) lat_rises++;
            if (o_valid) nvalid++;
            prev = o_pad_latch;
        end
        n_checks++;
        if (lat_rises != 0 || nvalid != 0)
            $display("FAIL drop_quiet: got latches=%0d valids=%0d want 0/0", lat_rises, nvalid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_up_a();
        test_timing();
        test_left_right_start();
        test_absent();
        test_select_down();
        test_reset_midframe();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion (%0d/%0d so far)", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
